// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: FSM states,
// opcodes, funct codes, internal ALU operation class and ALU function codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        RESET,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_SUB    = 2'b01,
        ALU_OP_FUNCT  = 2'b10,
        ALU_OP_UNUSED = 2'b11
    } alu_op_t;

    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's operation class and the R-type funct
// field onto the 3-bit ALU function.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_CTRL_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_CTRL_ADD;
            ALU_OP_SUB: alu_control = ALU_CTRL_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_CTRL_ADD;
                    FUNCT_SUB: alu_control = ALU_CTRL_SUB;
                    FUNCT_AND: alu_control = ALU_CTRL_AND;
                    FUNCT_OR:  alu_control = ALU_CTRL_OR;
                    FUNCT_SLT: alu_control = ALU_CTRL_SLT;
                    default:   alu_control = ALU_CTRL_AND;
                endcase
            end
            default: alu_control = ALU_CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS core. Moore outputs decoded from
// the state; memory states stretch on mem_ready, beq qualifies PC load by zero.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ior_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control
);

    state_t     state, next_state;
    alu_op_t    alu_op;
    logic       pc_write, branch;
    logic [2:0] alu_decoded;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RESET;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ior_d      = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_OP_ADD;
        case (state)
            RESET: next_state = FETCH;
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ior_d = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                ior_d     = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_OP_SUB;
                pc_src     = 2'b01;
                branch     = 1'b1;
                next_state = FETCH;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
            default: next_state = RESET;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_decoded)
    );

    // RESET drives every output low, including the ALU function.
    assign alu_control = (state == RESET) ? 3'b000 : alu_decoded;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: walks each instruction class
// and compares the packed output word against hand-written per-state values.
module tb_mips_multicycle_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mips_multicycle_controller dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .ior_d       (ior_d),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control)
    );

    // Field order: pc_en ior_d mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b pc_src alu_control
    wire [14:0] outs = {pc_en, ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                        alu_src_a, alu_src_b, pc_src, alu_control};

    localparam logic [14:0] V_RESET   = {8'b0000_0000, 2'b00, 2'b00, 3'b000};
    localparam logic [14:0] V_FETCH   = {8'b1001_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] V_STALL   = {8'b0000_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] V_DECODE  = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMADR  = {8'b0000_0001, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMRD   = {8'b0100_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMWB   = {8'b0000_0110, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMWR   = {8'b0110_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_ALUWB   = {8'b0000_1010, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_BR_Z    = {8'b1000_0001, 2'b00, 2'b01, 3'b110};
    localparam logic [14:0] V_BR_NZ   = {8'b0000_0001, 2'b00, 2'b01, 3'b110};
    localparam logic [14:0] V_ADDIEX  = {8'b0000_0001, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] V_ADDIWB  = {8'b0000_0010, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_JUMP    = {8'b1000_0000, 2'b00, 2'b10, 3'b010};
    localparam logic [11:0] EXEC_HEAD = {8'b0000_0001, 2'b00, 2'b00};

    typedef struct {
        logic [5:0] f;
        logic [2:0] alu;
    } funct_vec_t;

    funct_vec_t fvec [6] = '{
        '{6'b100000, 3'b010}, '{6'b100010, 3'b110}, '{6'b100100, 3'b000},
        '{6'b100101, 3'b001}, '{6'b101010, 3'b111}, '{6'b000111, 3'b000}
    };

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        #12;
        check("reset_hold", outs, V_RESET);
        reset_n = 1'b1;
        #1 check("reset_released", outs, V_RESET);
        cyc(); check("fetch_after_reset", outs, V_FETCH);

        // lw: 5 cycles
        opcode = 6'b100011;
        cyc(); check("lw_decode", outs, V_DECODE);
        cyc(); check("lw_memadr", outs, V_MEMADR);
        cyc(); check("lw_memrd", outs, V_MEMRD);
        cyc(); check("lw_memwb", outs, V_MEMWB);
        cyc(); check("lw_fetch", outs, V_FETCH);

        // R-type across funct codes: 4 cycles each
        opcode = 6'b000000;
        foreach (fvec[i]) begin
            funct = fvec[i].f;
            cyc(); check("r_decode", outs, V_DECODE);
            cyc(); check($sformatf("r_execute_%b", fvec[i].f), outs, {EXEC_HEAD, fvec[i].alu});
            cyc(); check("r_aluwb", outs, V_ALUWB);
            cyc(); check("r_fetch", outs, V_FETCH);
        end

        // beq taken then not taken
        opcode = 6'b000100;
        zero = 1'b1;
        cyc(); check("beq1_decode", outs, V_DECODE);
        cyc(); check("beq1_branch", outs, V_BR_Z);
        cyc(); check("beq1_fetch", outs, V_FETCH);
        zero = 1'b0;
        cyc(); check("beq0_decode", outs, V_DECODE);
        cyc(); check("beq0_branch", outs, V_BR_NZ);
        cyc(); check("beq0_fetch", outs, V_FETCH);

        // j
        opcode = 6'b000010;
        cyc(); check("j_decode", outs, V_DECODE);
        cyc(); check("j_jump", outs, V_JUMP);
        cyc(); check("j_fetch", outs, V_FETCH);

        // sw with 3 stall cycles in FETCH and in MEMWR
        opcode = 6'b101011;
        mem_ready = 1'b0;
        #1 check("stall_fetch_1", outs, V_STALL);
        cyc(); check("stall_fetch_2", outs, V_STALL);
        cyc(); check("stall_fetch_3", outs, V_STALL);
        mem_ready = 1'b1;
        #1 check("stall_fetch_ready", outs, V_FETCH);
        cyc(); check("sw_decode", outs, V_DECODE);
        cyc(); check("sw_memadr", outs, V_MEMADR);
        mem_ready = 1'b0;
        cyc(); check("stall_memwr_1", outs, V_MEMWR);
        cyc(); check("stall_memwr_2", outs, V_MEMWR);
        cyc(); check("stall_memwr_3", outs, V_MEMWR);
        mem_ready = 1'b1;
        #1 check("memwr_ready", outs, V_MEMWR);
        cyc(); check("sw_fetch", outs, V_FETCH);

        // unknown opcode: 2 cycles, no strobes
        opcode = 6'b111111;
        cyc(); check("unk_decode", outs, V_DECODE);
        cyc(); check("unk_fetch", outs, V_FETCH);

        // addi interrupted by async reset in ADDIWB
        opcode = 6'b001000;
        cyc(); check("addi_decode", outs, V_DECODE);
        cyc(); check("addi_ex", outs, V_ADDIEX);
        cyc(); check("addi_wb", outs, V_ADDIWB);
        #2 reset_n = 1'b0;
        #1 check("async_reset_drop", outs, V_RESET);
        cyc(); check("reset_held_edge", outs, V_RESET);
        #3 reset_n = 1'b1;
        #1 check("reset_release_2", outs, V_RESET);
        cyc(); check("fetch_after_reset_2", outs, V_FETCH);
        cyc(); check("addi2_decode", outs, V_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
